// File: rtl/wei_feed_ctrl.sv
// wei_feed_ctrl: sequencing controller for the SAURIA weight feeder.
// Turns one start command into the clear / feed / flush / context-switch /
// finish control stream, gated on feeder backpressure (fifo full, stall),
// and raises sticky deadlock and watchdog-timeout flags.
//
// Handshake: there is no valid/ready pair here. Commands are level-sampled
// on the rising clock edge: i_start only in IDLE, i_ctx_go only in CSW_WAIT,
// i_abort in every non-IDLE state with priority over every other transition.
// Progress (feed exit, flush count, watchdog reset) happens only on "adv"
// cycles, i.e. when the feeder reports neither fifo-full nor stall.
module wei_feed_ctrl #(
    parameter int FLUSH_CYCLES = 3,
    parameter int WDOG_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_ctx_go,
    input  logic              i_cnt_done,
    input  logic              i_til_done,
    input  logic              i_fifo_full,
    input  logic              i_feeder_stall,
    input  logic              i_fifo_empty,
    input  logic [WDOG_W-1:0] i_wdog_lim,
    output logic              o_cnt_en,
    output logic              o_cnt_clear,
    output logic              o_cswitch,
    output logic              o_feeder_en,
    output logic              o_feeder_clear,
    output logic              o_clearfifo,
    output logic              o_wei_valid,
    output logic              o_finalpush,
    output logic              o_busy,
    output logic              o_ctx_done,
    output logic              o_til_done,
    output logic              o_deadlock,
    output logic              o_timeout,
    output logic [2:0]        o_dbg_state
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_FEED     = 3'd2,
        S_FLUSH    = 3'd3,
        S_CSW_WAIT = 3'd4,
        S_CSW      = 3'd5,
        S_FIN      = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_flush_cnt;
    logic              r_abort;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_inc;
    logic              r_deadlock;
    logic              r_timeout;
    logic              w_adv;
    logic              w_flush_last;
    logic              w_wdog_run;

    assign w_adv        = !i_fifo_full && !i_feeder_stall;
    // Final advancing cycle of the flush: the FSM leaves FLUSH on this edge
    // unless an abort overrides it.
    assign w_flush_last = (r_state == S_FLUSH) && (r_flush_cnt == '0) && w_adv;
    // The watchdog only runs in states that wait on the feeder; CLEAR resets it.
    assign w_wdog_run   = (r_state != S_IDLE) && (r_state != S_CLEAR);
    assign w_wdog_inc   = (r_wdog == '1) ? r_wdog : (r_wdog + WDOG_W'(1));
    assign o_deadlock   = r_deadlock;
    assign o_timeout    = r_timeout;
    assign o_dbg_state  = r_state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore control outputs.
    always_comb begin
        w_state_nxt    = r_state;
        o_cnt_en       = 1'b0;
        o_cnt_clear    = 1'b0;
        o_cswitch      = 1'b0;
        o_feeder_en    = 1'b0;
        o_feeder_clear = 1'b0;
        o_clearfifo    = 1'b0;
        o_wei_valid    = 1'b0;
        o_finalpush    = 1'b0;
        o_busy         = (r_state != S_IDLE);
        o_til_done     = 1'b0;
        // The context-done pulse marks the flush exit cycle itself, so it is
        // qualified by the same adv/abort terms that decide the exit.
        o_ctx_done     = w_flush_last && !i_abort;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                o_cnt_clear    = 1'b1;
                o_feeder_clear = 1'b1;
                o_clearfifo    = 1'b1;
                w_state_nxt    = r_abort ? S_IDLE : S_FEED;
            end
            S_FEED: begin
                o_feeder_en = 1'b1;
                o_cnt_en    = 1'b1;
                o_wei_valid = 1'b1;
                if (i_cnt_done && w_adv) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                o_feeder_en = 1'b1;
                o_finalpush = 1'b1;
                if (w_flush_last) w_state_nxt = i_til_done ? S_FIN : S_CSW_WAIT;
            end
            S_CSW_WAIT: begin
                o_feeder_en = 1'b1;
                if (i_ctx_go) w_state_nxt = S_CSW;
            end
            S_CSW: begin
                o_cswitch   = 1'b1;
                w_state_nxt = S_FEED;
            end
            S_FIN: begin
                o_til_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every other transition outside IDLE.
        if ((r_state != S_IDLE) && i_abort) w_state_nxt = S_CLEAR;
    end

    // Flush counter: loaded on FEED->FLUSH, consumed only on adv cycles.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_flush_cnt <= '0;
        end else if ((r_state == S_FEED) && (w_state_nxt == S_FLUSH)) begin
            r_flush_cnt <= FC_LOAD;
        end else if ((r_state == S_FLUSH) && w_adv && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
        end
    end

    // Abort flag: remembers that the pending CLEAR must return to IDLE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_abort <= 1'b0;
        end else if ((r_state != S_IDLE) && i_abort) begin
            r_abort <= 1'b1;
        end else if (r_state == S_CLEAR) begin
            r_abort <= 1'b0;
        end
    end

    // Watchdog: consecutive no-progress cycles, saturating.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wdog <= '0;
        end else if (!w_wdog_run || w_adv) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_inc;
        end
    end

    // Sticky timeout: set on the stalled cycle that brings the count to the limit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_timeout <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_timeout <= 1'b0;
        end else if (w_wdog_run && !w_adv && (i_wdog_lim != '0) &&
                     (w_wdog_inc == i_wdog_lim)) begin
            r_timeout <= 1'b1;
        end
    end

    // Sticky deadlock: the feeder claims empty and full at the same time.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_deadlock <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_deadlock <= 1'b0;
        end else if ((r_state != S_IDLE) && i_fifo_empty && i_fifo_full) begin
            r_deadlock <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wei_feed_ctrl.sv
// Directed testbench for wei_feed_ctrl: linear sequence of steps with
// hand-computed output vectors, checked with immediate assertions.
module tb_wei_feed_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_ctx_go = 1'b0;
    logic       i_cnt_done = 1'b0;
    logic       i_til_done = 1'b0;
    logic       i_fifo_full = 1'b0;
    logic       i_feeder_stall = 1'b0;
    logic       i_fifo_empty = 1'b0;
    logic [9:0] i_wdog_lim = 10'd0;
    logic o_cnt_en, o_cnt_clear, o_cswitch, o_feeder_en, o_feeder_clear;
    logic o_clearfifo, o_wei_valid, o_finalpush, o_busy, o_ctx_done;
    logic o_til_done, o_deadlock, o_timeout;
    logic [2:0] o_dbg_state;

    logic [12:0] outs;

    int checks = 0;
    int errors = 0;

    // Output vector bit order (MSB first):
    // cnt_en cnt_clear cswitch feeder_en feeder_clear clearfifo wei_valid
    // finalpush busy ctx_done til_done deadlock timeout
    localparam logic [12:0] V_IDLE   = 13'b0000000000000;
    localparam logic [12:0] V_CLEAR  = 13'b0100110010000;
    localparam logic [12:0] V_FEED   = 13'b1001001010000;
    localparam logic [12:0] V_FLUSH  = 13'b0001000110000;
    localparam logic [12:0] V_FLUSHX = 13'b0001000111000;
    localparam logic [12:0] V_WAIT   = 13'b0001000010000;
    localparam logic [12:0] V_CSW    = 13'b0010000010000;
    localparam logic [12:0] V_FIN    = 13'b0000000010100;
    localparam logic [12:0] F_TO     = 13'b0000000000001;
    localparam logic [12:0] F_DL     = 13'b0000000000010;

    assign outs = {o_cnt_en, o_cnt_clear, o_cswitch, o_feeder_en, o_feeder_clear,
                   o_clearfifo, o_wei_valid, o_finalpush, o_busy, o_ctx_done,
                   o_til_done, o_deadlock, o_timeout};

    wei_feed_ctrl #(.FLUSH_CYCLES(3), .WDOG_W(10)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_ctx_go       (i_ctx_go),
        .i_cnt_done     (i_cnt_done),
        .i_til_done     (i_til_done),
        .i_fifo_full    (i_fifo_full),
        .i_feeder_stall (i_feeder_stall),
        .i_fifo_empty   (i_fifo_empty),
        .i_wdog_lim     (i_wdog_lim),
        .o_cnt_en       (o_cnt_en),
        .o_cnt_clear    (o_cnt_clear),
        .o_cswitch      (o_cswitch),
        .o_feeder_en    (o_feeder_en),
        .o_feeder_clear (o_feeder_clear),
        .o_clearfifo    (o_clearfifo),
        .o_wei_valid    (o_wei_valid),
        .o_finalpush    (o_finalpush),
        .o_busy         (o_busy),
        .o_ctx_done     (o_ctx_done),
        .o_til_done     (o_til_done),
        .o_deadlock     (o_deadlock),
        .o_timeout      (o_timeout),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock and reset block
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [12:0] exp);
        #1;
        check(tag, {3'b000, outs}, {3'b000, exp});
    endtask

    // Nominal tile: 5 FEED cycles, cnt_done on the 5th, til_done at flush exit.
    task automatic run_tile(input string tag);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out({tag, "_clear"}, V_CLEAR);
        check({tag, "_st_clear"}, {13'd0, o_dbg_state}, 16'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                i_cnt_done = 1'b1;
                i_til_done = 1'b1;
            end
            chk_out({tag, "_feed"}, V_FEED);
            tick();
        end
        i_cnt_done = 1'b0;
        chk_out({tag, "_flush0"}, V_FLUSH);
        tick();
        chk_out({tag, "_flush1"}, V_FLUSH);
        tick();
        chk_out({tag, "_flush2_ctxdone"}, V_FLUSHX);
        tick();
        i_til_done = 1'b0;
        chk_out({tag, "_fin"}, V_FIN);
        tick();
        chk_out({tag, "_idle"}, V_IDLE);
        check({tag, "_st_idle"}, {13'd0, o_dbg_state}, 16'd0);
    endtask

    // Directed stimulus, driver steps and scoreboard checks
    initial begin
        // ---- reset ----
        #1 i_rstn = 1'b0;
        chk_out("reset_outs", V_IDLE);
        check("reset_state", {13'd0, o_dbg_state}, 16'd0);
        tick();
        tick();
        i_rstn = 1'b1;
        chk_out("post_reset_idle", V_IDLE);

        // ---- nominal tile ----
        run_tile("nom");

        // ---- two contexts, start/ctx_go ignored in FEED ----
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("ctx_clear", V_CLEAR);
        tick();
        chk_out("ctx_feed0", V_FEED);
        i_start  = 1'b1;
        i_ctx_go = 1'b1;
        tick();
        i_start    = 1'b0;
        i_ctx_go   = 1'b0;
        i_cnt_done = 1'b1;
        chk_out("ctx_start_ignored", V_FEED);
        tick();
        i_cnt_done = 1'b0;
        chk_out("ctx_flush0", V_FLUSH);
        tick();
        chk_out("ctx_flush1", V_FLUSH);
        tick();
        chk_out("ctx_flush2_no_til", V_FLUSHX);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) i_ctx_go = 1'b1;
            chk_out("ctx_csw_wait", V_WAIT);
            tick();
        end
        i_ctx_go = 1'b0;
        chk_out("ctx_cswitch", V_CSW);
        tick();
        i_cnt_done = 1'b1;
        i_til_done = 1'b1;
        chk_out("ctx_feed_resume", V_FEED);
        tick();
        i_cnt_done = 1'b0;
        chk_out("ctx2_flush0", V_FLUSH);
        tick();
        chk_out("ctx2_flush1", V_FLUSH);
        tick();
        chk_out("ctx2_flush2", V_FLUSHX);
        tick();
        i_til_done = 1'b0;
        chk_out("ctx2_fin", V_FIN);
        tick();
        chk_out("ctx2_idle", V_IDLE);

        // ---- backpressure: cnt_done held during a stall, full mid-flush ----
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("bp_clear", V_CLEAR);
        tick();
        i_cnt_done     = 1'b1;
        i_feeder_stall = 1'b1;
        chk_out("bp_feed_stall", V_FEED);
        tick();
        i_feeder_stall = 1'b0;
        chk_out("bp_feed_held", V_FEED);
        tick();
        i_cnt_done = 1'b0;
        i_til_done = 1'b1;
        chk_out("bp_flush1", V_FLUSH);
        tick();
        i_fifo_full = 1'b1;
        chk_out("bp_flush2_full", V_FLUSH);
        tick();
        chk_out("bp_flush3_full", V_FLUSH);
        tick();
        i_fifo_full = 1'b0;
        chk_out("bp_flush4", V_FLUSH);
        tick();
        chk_out("bp_flush5_exit", V_FLUSHX);
        tick();
        i_til_done = 1'b0;
        chk_out("bp_fin", V_FIN);
        tick();
        chk_out("bp_idle", V_IDLE);

        // ---- abort: ignored in IDLE, wins over cnt_done in FEED ----
        i_abort = 1'b1;
        chk_out("ab_idle_ignored0", V_IDLE);
        tick();
        i_abort = 1'b0;
        chk_out("ab_idle_ignored1", V_IDLE);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("ab_clear0", V_CLEAR);
        tick();
        chk_out("ab_feed0", V_FEED);
        i_abort    = 1'b1;
        i_cnt_done = 1'b1;
        tick();
        i_abort    = 1'b0;
        i_cnt_done = 1'b0;
        chk_out("ab_clear", V_CLEAR);
        check("ab_state_clear", {13'd0, o_dbg_state}, 16'd1);
        tick();
        chk_out("ab_idle_busy_low", V_IDLE);

        // ---- watchdog and deadlock ----
        i_wdog_lim     = 10'd4;
        i_feeder_stall = 1'b1;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("wd_clear", V_CLEAR);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out("wd_stall_no_to", V_FEED);
            tick();
        end
        chk_out("wd_timeout_set", V_FEED | F_TO);
        i_fifo_empty = 1'b1;
        i_fifo_full  = 1'b1;
        tick();
        i_fifo_empty   = 1'b0;
        i_fifo_full    = 1'b0;
        i_feeder_stall = 1'b0;
        chk_out("wd_deadlock_set", V_FEED | F_TO | F_DL);
        i_cnt_done = 1'b1;
        i_til_done = 1'b1;
        tick();
        i_cnt_done = 1'b0;
        chk_out("wd_flush0_sticky", V_FLUSH | F_TO | F_DL);
        tick();
        tick();
        chk_out("wd_flush2_sticky", V_FLUSHX | F_TO | F_DL);
        tick();
        i_til_done = 1'b0;
        chk_out("wd_fin_sticky", V_FIN | F_TO | F_DL);
        tick();
        chk_out("wd_idle_sticky", F_TO | F_DL);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk_out("wd_clear_cycle", V_CLEAR | F_TO | F_DL);
        tick();
        chk_out("wd_flags_cleared", V_FEED);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        chk_out("wd_idle_after_abort", V_IDLE);
        i_wdog_lim = 10'd0;

        // ---- async reset mid-FLUSH ----
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_cnt_done = 1'b1;
        chk_out("rst_feed", V_FEED);
        tick();
        i_cnt_done = 1'b0;
        chk_out("rst_flush0", V_FLUSH);
        tick();
        chk_out("rst_flush1", V_FLUSH);
        i_rstn = 1'b0;
        chk_out("rst_async_outs", V_IDLE);
        check("rst_async_state", {13'd0, o_dbg_state}, 16'd0);
        tick();
        chk_out("rst_held", V_IDLE);
        i_rstn = 1'b1;
        run_tile("after_rst");

        // ---- final report ----
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
